// File: rtl/lfsr_rand_arbiter.sv
// Shares one 16-bit XNOR LFSR among NUM_REQ requesters via round-robin req/gnt,
// scaling each grant into [0, limit). Define GRANT_CNT_EN to add the grant_cnt output.
module lfsr_rand_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned WARMUP  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     seed_load,
  input  logic [15:0]              seed_val,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*OUT_W-1:0] req_limit,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rand_valid,
  output logic [OUT_W-1:0]         rand_out,
  output logic                     busy,
`ifdef GRANT_CNT_EN
  output logic [15:0]              grant_cnt,
`endif
  output logic [15:0]              lfsr_q
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  typedef enum logic {WARM, READY} state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 valid_q, valid_d;
  logic [OUT_W-1:0]     rand_q, rand_d;
  logic                 busy_q, busy_d;
  logic                 found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     idx;
  logic [OUT_W-1:0]     limit;
  logic [2*OUT_W-1:0]   prod;
  logic                 grant_fire;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    logic [15:0] s;
    s    = {q[14:0], q[15]};
    s[2] = q[1] ~^ q[15];
    s[3] = q[2] ~^ q[15];
    s[5] = q[4] ~^ q[15];
    return s;
  endfunction

  // First requester at or after the rr pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(rr_q) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    limit = req_limit[win_idx*OUT_W +: OUT_W];
    prod  = {{OUT_W{1'b0}}, lfsr_q[15 -: OUT_W]} * {{OUT_W{1'b0}}, limit};
  end

  assign grant_fire = !seed_load && (state_q == READY) && found;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    valid_d = 1'b0;
    rand_d  = '0;
    busy_d  = busy_q;
    if (seed_load) begin
      lfsr_d  = (seed_val == 16'hFFFF) ? 16'h0000 : seed_val;
      state_d = WARM;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        WARM: begin
          lfsr_d = lfsr_step(lfsr_q);
          if (cnt_q == 8'(WARMUP - 1)) begin
            state_d = READY;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        READY: begin
          if (found) begin
            gnt_d[win_idx] = 1'b1;
            valid_d        = 1'b1;
            rand_d         = prod[2*OUT_W-1:OUT_W];
            lfsr_d         = lfsr_step(lfsr_q);
            rr_d           = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
          end
        end
        default: state_d = WARM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WARM;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      rand_q  <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      rand_q  <= rand_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign rand_valid = valid_q;
  assign rand_out   = rand_q;
  assign busy       = busy_q;

`ifdef GRANT_CNT_EN
  logic [15:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    if (seed_load)
      gcnt_d = '0;
    else if (grant_fire && gcnt_q != '1)
      gcnt_d = gcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gcnt_q <= '0;
    else      gcnt_q <= gcnt_d;
  end

  assign grant_cnt = gcnt_q;
`else
  logic unused_fire;
  assign unused_fire = grant_fire;
`endif

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Self-checking bench for lfsr_rand_arbiter (NUM_REQ=4, OUT_W=8, WARMUP=2)
// against a cycle-level behavioural model of the shared random source.
module tb_lfsr_rand_arbiter;

  localparam int NREQ = 4;
  localparam int OW   = 8;
  localparam int WU   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            seed_load;
  logic [15:0]     seed_val;
  logic [NREQ-1:0] req;
  logic [NREQ*OW-1:0] req_limit;
  logic [NREQ-1:0] gnt;
  logic            rand_valid;
  logic [OW-1:0]   rand_out;
  logic            busy;
  logic [15:0]     lfsr_q;
`ifdef GRANT_CNT_EN
  logic [15:0]     grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // model state and expected outputs
  logic [15:0] m_lfsr;
  int          m_warm_left;
  bit          m_busy;
  int          m_rr;
  int          m_gcnt;
  int          lims[NREQ];
  logic [3:0]  e_gnt;
  bit          e_valid;
  int          e_rand;
  int          e_lim;

  lfsr_rand_arbiter #(.NUM_REQ(NREQ), .OUT_W(OW), .WARMUP(WU)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_val(seed_val),
    .req(req), .req_limit(req_limit), .gnt(gnt), .rand_valid(rand_valid),
    .rand_out(rand_out), .busy(busy),
`ifdef GRANT_CNT_EN
    .grant_cnt(grant_cnt),
`endif
    .lfsr_q(lfsr_q)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Galois view of the XNOR LFSR: shift in the top bit, then invert taps 2,3,5 when it was 0.
  function automatic logic [15:0] m_next(input logic [15:0] q);
    logic [15:0] s;
    s = {q[14:0], q[15]};
    return q[15] ? s : (s ^ 16'h002C);
  endfunction

  function automatic void model_reset();
    m_lfsr = 16'h0000; m_warm_left = WU; m_busy = 1; m_rr = 0; m_gcnt = 0;
    e_gnt = '0; e_valid = 0; e_rand = 0; e_lim = 0;
  endfunction

  function automatic void set_limits();
    for (int k = 0; k < NREQ; k++) req_limit[k*OW +: OW] = OW'(lims[k]);
  endfunction

  function automatic void model_step();
    e_gnt = '0; e_valid = 0; e_rand = 0; e_lim = 0;
    if (seed_load) begin
      m_lfsr = (seed_val == 16'hFFFF) ? 16'h0000 : seed_val;
      m_warm_left = WU; m_busy = 1; m_gcnt = 0;
    end else if (m_busy) begin
      m_lfsr = m_next(m_lfsr);
      m_warm_left--;
      if (m_warm_left == 0) m_busy = 0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_rr + i) % NREQ;
        if (req[k]) begin
          e_gnt   = 4'(1 << k);
          e_valid = 1;
          e_lim   = lims[k];
          e_rand  = (int'(m_lfsr >> 8) * lims[k]) >> 8;
          m_lfsr  = m_next(m_lfsr);
          m_rr    = (k + 1) % NREQ;
          if (m_gcnt < 65535) m_gcnt++;
          break;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; seed_load = 0; seed_val = '0; req = '0;
    for (int k = 0; k < NREQ; k++) lims[k] = 0;
    set_limits();
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %h want 0", gnt); end
    checks++; if (rand_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rand_valid); end
    checks++; if (rand_out !== 8'h00) begin errors++; $display("FAIL reset_rand got %h want 00", rand_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    checks++; if (lfsr_q !== 16'h0000) begin errors++; $display("FAIL reset_lfsr got %h want 0000", lfsr_q); end
`ifdef GRANT_CNT_EN
    checks++; if (grant_cnt !== 16'h0000) begin errors++; $display("FAIL reset_gcnt got %h want 0000", grant_cnt); end
`endif
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_warmup();
    logic [15:0] want_l[2];
    want_l[0] = 16'h002C; want_l[1] = 16'h0074;
    for (int c = 0; c < 2; c++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL warm_busy%0d got %b want 1", c, busy); end
      model_step(); tick();
      checks++; if (lfsr_q !== want_l[c]) begin errors++; $display("FAIL warm_lfsr%0d got %h want %h", c, lfsr_q, want_l[c]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL warm_done_busy got %b want 0", busy); end
    for (int c = 0; c < 3; c++) begin
      model_step(); tick();
      checks++; if (lfsr_q !== 16'h0074 || gnt !== 4'b0000)
        begin errors++; $display("FAIL idle_hold got lfsr %h gnt %b want 0074 0000", lfsr_q, gnt); end
    end
  endtask

  task automatic test_single();
    lims[0] = 10; set_limits();
    req = 4'b0001;
    model_step(); tick();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0001 || rand_valid !== 1'b1)
      begin errors++; $display("FAIL single_gnt got %b/%b want 0001/1", gnt, rand_valid); end
    checks++; if (rand_out !== 8'd0) begin errors++; $display("FAIL single_rand got %0d want 0", rand_out); end
    checks++; if (lfsr_q !== 16'h00C4) begin errors++; $display("FAIL single_step got %h want 00C4", lfsr_q); end
    model_step(); tick();
    checks++; if (gnt !== 4'b0000 || rand_valid !== 1'b0 || rand_out !== 8'd0)
      begin errors++; $display("FAIL single_after got %b/%b/%0d want 0/0/0", gnt, rand_valid, rand_out); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want_g[5];
    // pointer sits at 1 after the single grant to requester 0
    want_g[0] = 4'b0010; want_g[1] = 4'b0100; want_g[2] = 4'b1000; want_g[3] = 4'b0001; want_g[4] = 4'b0010;
    for (int k = 0; k < NREQ; k++) lims[k] = 200;
    set_limits();
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      model_step(); tick();
      checks++; if (gnt !== want_g[c]) begin errors++; $display("FAIL rr_seq%0d got %b want %b", c, gnt, want_g[c]); end
      checks++; if (rand_out !== OW'(e_rand) || lfsr_q !== m_lfsr)
        begin errors++; $display("FAIL rr_data%0d got %0d/%h want %0d/%h", c, rand_out, lfsr_q, e_rand, m_lfsr); end
    end
  endtask

  task automatic test_seed_ffff();
    req = 4'b0011; seed_load = 1; seed_val = 16'hFFFF;
    model_step(); tick();
    seed_load = 0;
    checks++; if (gnt !== 4'b0000 || rand_valid !== 1'b0)
      begin errors++; $display("FAIL seed_nognt got %b/%b want 0/0", gnt, rand_valid); end
    checks++; if (lfsr_q !== 16'h0000) begin errors++; $display("FAIL seed_lfsr got %h want 0000", lfsr_q); end
    for (int c = 0; c < WU; c++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seed_busy%0d got %b want 1", c, busy); end
      model_step(); tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL seed_warm_gnt%0d got %b want 0", c, gnt); end
    end
    checks++; if (busy !== 1'b0 || lfsr_q !== 16'h0074)
      begin errors++; $display("FAIL seed_ready got busy %b lfsr %h want 0 0074", busy, lfsr_q); end
    // pointer was at 2 before the seed load: 2,3 not requesting, so 0 wins
    model_step(); tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL seed_resume got %b want 0001", gnt); end
    req = '0;
  endtask

  task automatic test_random();
    int grants = 0;
    int cyc = 0;
    int pick[4];
    pick[0] = 0; pick[1] = 1; pick[2] = 7; pick[3] = 200;
    while (grants < 1000 && cyc < 20000) begin
      cyc++;
      seed_load = ($urandom_range(0, 199) == 0);
      seed_val  = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      req       = 4'($urandom);
      for (int k = 0; k < NREQ; k++) lims[k] = pick[$urandom_range(0, 3)];
      set_limits();
      model_step(); tick();
      checks++;
      if (gnt !== e_gnt || rand_valid !== e_valid || rand_out !== OW'(e_rand) || lfsr_q !== m_lfsr || busy !== m_busy) begin
        errors++;
        $display("FAIL rand_cyc%0d got g%b v%b r%0d l%h b%b want g%b v%b r%0d l%h b%b", cyc,
                 gnt, rand_valid, rand_out, lfsr_q, busy, e_gnt, e_valid, e_rand, m_lfsr, m_busy);
      end
`ifdef GRANT_CNT_EN
      checks++; if (grant_cnt !== 16'(m_gcnt)) begin errors++; $display("FAIL rand_gcnt got %0d want %0d", grant_cnt, m_gcnt); end
`endif
      if (rand_valid === 1'b1) begin
        grants++;
        checks++;
        if ((e_lim == 0 && rand_out !== 8'd0) || (e_lim > 0 && int'(rand_out) >= e_lim)) begin
          errors++; $display("FAIL rand_range got %0d limit %0d", rand_out, e_lim);
        end
      end
    end
    seed_load = 0; req = '0;
    checks++; if (grants < 1000) begin errors++; $display("FAIL rand_budget got %0d grants want 1000", grants); end
  endtask

  task automatic test_reset_mid();
    seed_load = 1; seed_val = 16'h1234; req = '0;
    model_step(); tick();
    seed_load = 0;
    model_step(); tick();
    #2 rst = 1'b0;
    #1;
    checks++; if (lfsr_q !== 16'h0000 || busy !== 1'b1 || gnt !== 4'b0000)
      begin errors++; $display("FAIL rst_warm got lfsr %h busy %b gnt %b want 0000 1 0", lfsr_q, busy, gnt); end
    tick();
    rst = 1'b1; model_reset();
    for (int c = 0; c < WU; c++) begin model_step(); tick(); end
    req = 4'b0100;
    model_step(); tick();
    checks++; if (gnt !== 4'b0100 || rand_valid !== 1'b1)
      begin errors++; $display("FAIL rst_pre_gnt got %b/%b want 0100/1", gnt, rand_valid); end
`ifdef GRANT_CNT_EN
    checks++; if (grant_cnt !== 16'd1) begin errors++; $display("FAIL rst_gcnt_inc got %0d want 1", grant_cnt); end
`endif
    #2 rst = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000 || rand_valid !== 1'b0 || rand_out !== 8'd0 || lfsr_q !== 16'h0000)
      begin errors++; $display("FAIL rst_grant got %b/%b/%0d/%h want 0/0/0/0000", gnt, rand_valid, rand_out, lfsr_q); end
`ifdef GRANT_CNT_EN
    checks++; if (grant_cnt !== 16'd0) begin errors++; $display("FAIL rst_gcnt got %0d want 0", grant_cnt); end
`endif
    req = '0;
    tick();
    rst = 1'b1; model_reset();
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_single();
    test_back_to_back();
    test_seed_ffff();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
- Owns one 16-bit XNOR LFSR. Shares its random values among NUM_REQ requesters (spawn placement, enemy AI, loot) through round-robin arbitration and a req/gnt handshake.
- Sequences the LFSR: reset, seed load, warm-up stepping, and exactly one step per grant. Every requester therefore sees a deterministic, non-repeating stream.
- Scales each granted value into the range [0, limit) supplied by that requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- OUT_W, 8, width of the range limit and of rand_out (1..16).
- WARMUP, 16, LFSR steps after reset or seed load before the first grant (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- seed_load  in  1  one-cycle pulse; load seed_val and restart warm-up.
- seed_val  in  16  seed value.
- req  in  NUM_REQ  request per requester; held until gnt.
- req_limit  in  NUM_REQ*OUT_W  per-requester range limit; requester i uses bits [i*OUT_W +: OUT_W].
- gnt  out  NUM_REQ  one-hot grant, one cycle.
- rand_valid  out  1  rand_out valid; coincides with gnt.
- rand_out  out  OUT_W  scaled random value for the granted requester.
- busy  out  1  high during warm-up.
- lfsr_q  out  16  current LFSR state (debug/verification).

Behaviour:
- Reset (rst=0, async):
  - lfsr_q=16'h0000, state=WARM, warm counter=0, rr pointer=0.
  - gnt=0, rand_valid=0, rand_out=0, busy=1.
  - A reset mid-warm-up or mid-grant aborts immediately. No grant is issued in the cycle reset is asserted.
- LFSR step:
  - fb=q[15]; q[0]<=fb; q[1]<=q[0].
  - q[2]<=q[1]~^fb; q[3]<=q[2]~^fb; q[5]<=q[4]~^fb.
  - All other bits: q[i]<=q[i-1].
  - Lock-up state is 16'hFFFF. A seed of 16'hFFFF is loaded as 16'h0000.
- FSM states: WARM, READY.
  - WARM: LFSR steps every cycle. After WARMUP steps, go to READY and drop busy (busy=0 in the first READY cycle).
  - READY: LFSR steps only on a grant.
- seed_load (either state):
  - Next cycle: lfsr_q=seed_val (after the FFFF substitution), state=WARM, counter=0, busy=1.
  - Takes priority over a grant in the same cycle: no gnt issued, req is ignored for that cycle, rr pointer unchanged.
- Arbitration (READY, no seed_load):
  - Round-robin search over req starting at the rr pointer.
  - Winner k gets gnt[k]=1 and rand_valid=1 registered one cycle after req is sampled (latency 1).
  - rr pointer <= k+1 (mod NUM_REQ).
  - A grant is possible every cycle (back-to-back).
  - A requester that still holds req after its gnt is re-eligible; fairness is guaranteed by the pointer.
  - Dropping req before gnt is legal and produces no grant.
- Scaling:
  - rand_out = (lfsr_q[15 -: OUT_W] * limit_k) >> OUT_W, computed at full width 2*OUT_W, using the pre-step LFSR value.
  - Result is always < limit_k when limit_k>0. limit_k=0 gives rand_out=0.
- Outputs gnt, rand_valid, rand_out are registered and zero when no grant. rand_out holds 0 outside rand_valid.

Optional Feature:
- GRANT_CNT_EN defined:
  - Extra output grant_cnt[15:0] counts grants since reset or the last seed_load.
  - Saturates at 16'hFFFF. Cleared by reset and by seed_load.
- GRANT_CNT_EN undefined: port and counter are absent.

Test Plan:
- WARMUP=2, reset released, no req:
  - busy=1 for 2 cycles, lfsr_q 0000 -> 002C -> 0074, then busy=0.
  - lfsr_q holds at 0074 while idle.
- WARMUP=2, req=4'b0001, limit0=8'd10 after busy falls:
  - gnt=0001 and rand_valid one cycle later, rand_out=0 (top byte 0x00).
  - lfsr_q -> next state (one step only).
- All four req held high continuously:
  - gnt sequence 0001, 0010, 0100, 1000, 0001, one per cycle.
- seed_load with seed_val=16'hFFFF during READY while req=0011:
  - No gnt that cycle, lfsr_q=0000, busy=1 for WARMUP cycles.
  - Grants resume at the same rr position.
- Random seeds, 1000 grants with limit values 1, 7, 200:
  - rand_out<limit always; limit=0 gives rand_out=0.
- Reset asserted mid-warm-up and mid-grant:
  - All outputs 0 and lfsr_q=0000 immediately (async).
  - With GRANT_CNT_EN: grant_cnt=0 after reset, and increments 1 per gnt.
